// File: rtl/data_ram_responder.sv
// Byte-lane data memory answering MEM-stage load/store requests, with post-reset clear.
// Latency: loads return combinationally in the request cycle; stores land at the next posedge.
// Backpressure: none; requests are ignored while busy_o is high, otherwise complete in one cycle.
module data_ram_responder #(
    parameter int WORD_AW = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        busy_o,
    output logic        err_o,
    output logic [31:0] err_addr_o,
    output logic [31:0] rd_cnt_o,
    output logic [31:0] wr_cnt_o
);
    localparam int DEPTH = 1 << WORD_AW;

    typedef enum logic {CLEAR, READY} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [WORD_AW-1:0]   clr_ptr;
    logic [31:0]          mem [DEPTH];

    logic [WORD_AW-1:0]   idx;
    logic                 in_range;
    logic                 legal_sel;
    logic                 valid;
    logic [31:0]          lane_mask;

    logic                 mem_we;
    logic [WORD_AW-1:0]   mem_idx;
    logic [31:0]          mem_wdat;
    logic [3:0]           mem_be;
    logic                 do_rd;
    logic                 do_wr;
    logic                 do_err;

    // Lane is chosen by sel_i alone; the low address bits carry no information.
    logic                 unused_addr_lsb;
    assign unused_addr_lsb = ^addr_i[1:0];

    assign idx       = addr_i[WORD_AW+1:2];
    assign in_range  = (addr_i[31:WORD_AW+2] == '0);
    assign lane_mask = {{8{sel_i[3]}}, {8{sel_i[2]}}, {8{sel_i[1]}}, {8{sel_i[0]}}};
    assign valid     = in_range & legal_sel;

    // Only naturally aligned byte, halfword and word selects are accepted.
    always_comb begin
        legal_sel = 1'b0;
        case (sel_i)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: legal_sel = 1'b1;
            default:                   legal_sel = 1'b0;
        endcase
    end

    // Next state, memory write port steering and combinational load data.
    always_comb begin
        state_nxt = state;
        data_o    = '0;
        mem_we    = 1'b0;
        mem_idx   = idx;
        mem_wdat  = data_i;
        mem_be    = sel_i;
        do_rd     = 1'b0;
        do_wr     = 1'b0;
        do_err    = 1'b0;
        case (state)
            CLEAR: begin
                mem_we   = 1'b1;
                mem_idx  = clr_ptr;
                mem_wdat = '0;
                mem_be   = 4'hF;
                if (&clr_ptr) state_nxt = READY;
            end
            READY: begin
                if (ce_i) begin
                    if (!valid) begin
                        do_err = 1'b1;
                    end else if (we_i) begin
                        mem_we = 1'b1;
                        do_wr  = 1'b1;
                    end else begin
                        data_o = mem[idx] & lane_mask;
                        do_rd  = 1'b1;
                    end
                end
            end
            default: state_nxt = CLEAR;
        endcase
    end

    // State register; reset always restarts the clear sweep.
    always_ff @(posedge clk) begin
        if (rst) state <= CLEAR;
        else     state <= state_nxt;
    end

    // Clear pointer and busy flag; busy drops on the cycle after the last word is cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            clr_ptr <= '0;
            busy_o  <= 1'b1;
        end else if (state == CLEAR) begin
            clr_ptr <= clr_ptr + 1'b1;
            if (&clr_ptr) busy_o <= 1'b0;
        end
    end

    // Byte-lane memory write, shared by the clear sweep and stores.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_be[i]) mem[mem_idx][8*i +: 8] <= mem_wdat[8*i +: 8];
            end
        end
    end

    // Access counters and first-error capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt_o   <= '0;
            wr_cnt_o   <= '0;
            err_o      <= 1'b0;
            err_addr_o <= '0;
        end else begin
            if (do_rd) rd_cnt_o <= rd_cnt_o + 32'd1;
            if (do_wr) wr_cnt_o <= wr_cnt_o + 32'd1;
            if (do_err && !err_o) begin
                err_o      <= 1'b1;
                err_addr_o <= addr_i;
            end
        end
    end
endmodule
